// File: rtl/result_collector.sv
// result_collector
//
// Captures the four result elements of one vector pass from the datapath,
// packs them into a 32-bit word and queues the word in a show-ahead FIFO.
// The FIFO drains to the host or memory side over a valid/ready interface.
//
// Ports:
//   clk          in   1      clock
//   reset        in   1      asynchronous, active-high reset
//   state        in   4      datapath control state (Gray-coded)
//   f            in   8      datapath result byte
//   clear_flags  in   1      synchronous clear of overflow and seq_err
//   out_data     out  32     FIFO head word; element 1 in [7:0], element 4 in [31:24]
//   out_valid    out  1      FIFO non-empty
//   out_ready    in   1      consumer accepts the head word
//   count        out  CW     FIFO occupancy
//   overflow     out  1      sticky: a completed word was dropped (FIFO full)
//   seq_err      out  1      sticky: a capture was aborted (state sequence broke)
//   dbg_state    out  3      {capture FSM state, element index}
//
// Handshake: a word transfers on every rising clk edge where out_valid and
// out_ready are both high. out_valid never depends on out_ready, and out_data
// stays stable while out_valid is high and no transfer has happened.
module result_collector #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               state,
    input  logic [7:0]               f,
    input  logic                     clear_flags,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     seq_err,
    output logic [2:0]               dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Datapath state codes
    localparam logic [3:0] S1  = 4'b0000;
    localparam logic [3:0] S2  = 4'b0001;
    localparam logic [3:0] S3  = 4'b0011;
    localparam logic [3:0] S4  = 4'b0010;
    localparam logic [3:0] S12 = 4'b1000;

    // Capture FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CAP  = 1'b1;

    logic [0:0]    fsm;
    logic [1:0]    idx;
    logic [23:0]   partial;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic [3:0]    exp_state;
    logic          match;
    logic          push;
    logic          seq_fail;
    logic [31:0]   word;
    logic          pop;
    logic          full;
    logic          do_write;
    logic          drop;

    // Element k is stable on f while the datapath shows the state that
    // follows the one producing it, so index k expects S1..S4 in turn.
    always_comb begin
        exp_state = S1;
        case (idx)
            2'd0:    exp_state = S1;
            2'd1:    exp_state = S2;
            2'd2:    exp_state = S3;
            default: exp_state = S4;
        endcase
    end

    assign match    = (state == exp_state);
    assign push     = (fsm == ST_CAP) && match && (idx == 2'd3);
    assign seq_fail = (fsm == ST_CAP) && !match;
    assign word     = {f, partial[23:16], partial[15:8], partial[7:0]};

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (count == FULL_COUNT);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_write  = push && (!full || pop);
    assign drop      = push && full && !pop;

    assign out_data  = out_valid ? mem[rd_ptr] : 32'd0;
    assign dbg_state = {fsm, idx};

    // Capture FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm     <= ST_IDLE;
            idx     <= 2'd0;
            partial <= 24'd0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (state == S12) begin
                        fsm <= ST_CAP;
                        idx <= 2'd0;
                    end
                end
                ST_CAP: begin
                    if (match) begin
                        if (idx == 2'd3) begin
                            fsm <= ST_IDLE;
                            idx <= 2'd0;
                        end else begin
                            case (idx)
                                2'd0:    partial[7:0]   <= f;
                                2'd1:    partial[15:8]  <= f;
                                default: partial[23:16] <= f;
                            endcase
                            idx <= idx + 2'd1;
                        end
                    end else begin
                        // Broken sequence: drop the partial word; S12 re-arms.
                        partial <= 24'd0;
                        idx     <= 2'd0;
                        fsm     <= (state == S12) ? ST_CAP : ST_IDLE;
                    end
                end
                default: begin
                    fsm <= ST_IDLE;
                    idx <= 2'd0;
                end
            endcase
        end
    end

    // FIFO storage needs no reset: out_data is forced to 0 while empty.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= word;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_write, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flags; a new event in the clearing cycle wins over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            overflow <= drop     | (overflow & ~clear_flags);
            seq_err  <= seq_fail | (seq_err  & ~clear_flags);
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// Testbench for result_collector.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, half a cycle after the rising edge that updated them.
module tb_result_collector;

    localparam int DEPTH = 4;

    localparam logic [3:0] S1  = 4'b0000;
    localparam logic [3:0] S2  = 4'b0001;
    localparam logic [3:0] S3  = 4'b0011;
    localparam logic [3:0] S4  = 4'b0010;
    localparam logic [3:0] S12 = 4'b1000;
    localparam logic [3:0] S5  = 4'b0110;
    localparam logic [3:0] SX  = 4'b1111;

    logic        clk;
    logic        reset;
    logic [3:0]  state;
    logic [7:0]  f;
    logic        clear_flags;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic        overflow;
    logic        seq_err;
    logic [2:0]  dbg_state;

    result_collector #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .state      (state),
        .f          (f),
        .clear_flags(clear_flags),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .overflow   (overflow),
        .seq_err    (seq_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic        exp_ovf;
    int          total;
    int          bad;

    // Values applied by the driver at the next falling edge
    logic        drv_ready;
    logic        drv_clear;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, apply inputs, update
    // the model for the coming rising edge, then let the edge happen.
    task automatic tick(input logic [3:0] st, input logic [7:0] fv,
                        input bit psh, input logic [31:0] w);
        @(negedge clk);
        check_val("count", 32'(count), 32'(exp_q.size()));
        check_val("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check_val("overflow", 32'(overflow), 32'(exp_ovf));
        if (exp_q.size() == 0) check_val("out_data_empty", out_data, 32'd0);
        state       = st;
        f           = fv;
        out_ready   = drv_ready;
        clear_flags = drv_clear;
        if (drv_clear) exp_ovf = 1'b0;
        if (drv_ready && exp_q.size() != 0) begin
            check_val("out_data", out_data, exp_q.pop_front());
        end
        if (psh) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(w);
            else exp_ovf = 1'b1;
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(SX, 8'h00, 1'b0, 32'd0);
    endtask

    task automatic run_pass(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        tick(S12, $urandom_range(0, 255), 1'b0, 32'd0);
        tick(S1, a, 1'b0, 32'd0);
        tick(S2, b, 1'b0, 32'd0);
        tick(S3, c, 1'b0, 32'd0);
        tick(S4, d, 1'b1, {d, c, b, a});
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_data", out_data, 32'd0);
        check_val("rst_overflow", 32'(overflow), 32'd0);
        check_val("rst_seq_err", 32'(seq_err), 32'd0);
        check_val("rst_dbg_state", 32'(dbg_state), 32'd0);
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total       = 0;
        bad         = 0;
        exp_ovf     = 1'b0;
        drv_ready   = 1'b0;
        drv_clear   = 1'b0;
        reset       = 1'b1;
        state       = SX;
        f           = 8'h00;
        clear_flags = 1'b0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("init_count", 32'(count), 32'd0);
        check_val("init_valid", 32'(out_valid), 32'd0);
        check_val("init_data", out_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Single pass drained immediately
        drv_ready = 1'b1;
        run_pass(8'h11, 8'h22, 8'h33, 8'h44);
        idle(2);
        check_val("single_seq_err", 32'(seq_err), 32'd0);

        // Fill and overflow
        drv_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            run_pass(8'(8'h00 + k), 8'(8'h10 + k), 8'(8'h20 + k), 8'(8'h30 + k));
            idle($urandom_range(0, 3));
        end
        idle(1);
        check_val("ovf_set", 32'(overflow), 32'd1);
        drv_clear = 1'b1;
        idle(1);
        drv_clear = 1'b0;
        idle(1);

        // Full FIFO with push and pop on the same edge
        tick(S12, 8'h00, 1'b0, 32'd0);
        tick(S1, 8'h06, 1'b0, 32'd0);
        tick(S2, 8'h16, 1'b0, 32'd0);
        tick(S3, 8'h26, 1'b0, 32'd0);
        drv_ready = 1'b1;
        tick(S4, 8'h36, 1'b1, 32'h36261606);
        drv_ready = 1'b0;
        idle(1);
        check_val("full_pp_count", 32'(count), 32'd4);
        drv_ready = 1'b1;
        idle(6);

        // Sequence break by an unrelated state
        tick(S12, 8'h00, 1'b0, 32'd0);
        tick(S1, 8'h01, 1'b0, 32'd0);
        tick(S2, 8'h02, 1'b0, 32'd0);
        tick(S5, 8'h03, 1'b0, 32'd0);
        idle(1);
        check_val("seq_err_break", 32'(seq_err), 32'd1);
        drv_clear = 1'b1;
        idle(1);
        drv_clear = 1'b0;
        idle(1);
        check_val("seq_err_cleared", 32'(seq_err), 32'd0);

        // Re-arm on S12 mid-capture
        tick(S12, 8'h00, 1'b0, 32'd0);
        tick(S1, 8'h55, 1'b0, 32'd0);
        tick(S12, 8'h00, 1'b0, 32'd0);
        tick(S1, 8'hAA, 1'b0, 32'd0);
        check_val("seq_err_rearm", 32'(seq_err), 32'd1);
        tick(S2, 8'hBB, 1'b0, 32'd0);
        tick(S3, 8'hCC, 1'b0, 32'd0);
        tick(S4, 8'hDD, 1'b1, 32'hDDCCBBAA);
        idle(2);
        drv_clear = 1'b1;
        idle(1);
        drv_clear = 1'b0;
        idle(1);
        check_val("seq_err_clr2", 32'(seq_err), 32'd0);

        // Error in the clearing cycle: set wins
        tick(S12, 8'h00, 1'b0, 32'd0);
        drv_clear = 1'b1;
        tick(S3, 8'h00, 1'b0, 32'd0);
        drv_clear = 1'b0;
        idle(1);
        check_val("seq_err_set_wins", 32'(seq_err), 32'd1);

        // Reset mid-capture with a word already queued
        drv_ready = 1'b0;
        run_pass(8'h71, 8'h72, 8'h73, 8'h74);
        tick(S12, 8'h00, 1'b0, 32'd0);
        tick(S1, 8'h81, 1'b0, 32'd0);
        tick(S2, 8'h82, 1'b0, 32'd0);
        pulse_reset();
        tick(S3, 8'h83, 1'b0, 32'd0);
        tick(S4, 8'h84, 1'b0, 32'd0);
        idle(2);
        check_val("post_rst_count", 32'(count), 32'd0);

        // A complete pass after reset works normally
        drv_ready = 1'b1;
        run_pass(8'h9A, 8'h9B, 8'h9C, 8'h9D);
        idle(3);
        check_val("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
